// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the memory access unit: the 4-bit access-type
// encoding, the access FSM state type, and small decode helpers used to
// classify a request and to build its byte-lane enable mask.
// -----------------------------------------------------------------------------
package mips_mem_pkg;

    // Access type encoding (codes 7 and 11..15 are illegal)
    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic op_is_load(input logic [3:0] op);
        logic res;
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LWL, OP_LWR: res = 1'b1;
            default:                                             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        logic res;
        case (op)
            OP_SB, OP_SH, OP_SW: res = 1'b1;
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

    // Byte ops and the unaligned LWL/LWR pair can never be misaligned.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic res;
        case (op)
            OP_LH, OP_LHU, OP_SH: res = lane[0];
            OP_LW, OP_SW:         res = |lane;
            default:              res = 1'b0;
        endcase
        return res;
    endfunction

    // Bit k of the mask enables the byte at word address + k.
    function automatic logic [3:0] lane_enable(input logic [3:0] op, input logic [1:0] lane);
        logic [3:0] be;
        case (op)
            OP_LB, OP_LBU, OP_SB: be = 4'b0001 << lane;
            OP_LH, OP_LHU, OP_SH: be = lane[1] ? 4'b1100 : 4'b0011;
            OP_LW, OP_SW:         be = 4'b1111;
            OP_LWL:               be = 4'b1111 >> (2'd3 - lane);  // lanes 0..k
            OP_LWR:               be = 4'b1111 << lane;           // lanes k..3
            default:              be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// -----------------------------------------------------------------------------
// load_align
// Combinational load result formatter. Picks the addressed byte/halfword out
// of the memory word and sign- or zero-extends it, passes whole words through,
// and builds the LWL/LWR merge of memory bytes with the old register value.
// Ports:
//   op       - captured access type
//   lane     - captured addr[1:0]
//   mem_word - word read from memory (little-endian lanes)
//   rt_word  - captured register value, merge source for LWL/LWR
//   result   - formatted load value
// -----------------------------------------------------------------------------
module load_align
    import mips_mem_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] rt_word,
    output logic [31:0] result
);

    logic [7:0]  mem_byte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [4:0]  lwl_shift;
    logic [4:0]  lwr_shift;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_byte[gi] = mem_word[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte  = mem_byte[lane];
        sel_half  = lane[1] ? mem_word[31:16] : mem_word[15:0];
        // LWL moves memory lanes 0..k up to the top of the register;
        // LWR moves lanes k..3 down to the bottom.
        lwl_shift = {2'd3 - lane, 3'b000};
        lwr_shift = {lane, 3'b000};
        case (op)
            OP_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            OP_LBU:  result = {24'h0, sel_byte};
            OP_LH:   result = {{16{sel_half[15]}}, sel_half};
            OP_LHU:  result = {16'h0, sel_half};
            OP_LW:   result = mem_word;
            OP_LWL:  result = (mem_word << lwl_shift)
                            | (rt_word & ((32'h1 << lwl_shift) - 32'h1));
            OP_LWR:  result = (mem_word >> lwr_shift)
                            | (rt_word & ~(32'hFFFF_FFFF >> lwr_shift));
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Executes one byte/half/word/unaligned load or store per start strobe over a
// single 32-bit data port. Illegal ops and misaligned requests complete with
// addr_error in one cycle without touching memory.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, op, addr,    - request strobe and operands (sampled in IDLE)
//   rt_data
//   busy, done,         - status; done pulses one cycle, addr_error with done
//   addr_error
//   load_data           - load result, held until the next load completes
//   dp_address, writedata, byteenable, read_dp, write_dp - data-port request
//   dp_data             - memory read data (valid while read_dp high)
//   stall               - memory not ready, request held while high
// -----------------------------------------------------------------------------
module mem_access_unit
    import mips_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        addr_error,
    output logic [31:0] dp_address,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    output logic        read_dp,
    output logic        write_dp,
    input  logic [31:0] dp_data,
    input  logic        stall
);

    state_t      state_reg;
    logic [3:0]  op_reg;
    logic [1:0]  lane_reg;
    logic [31:0] rt_reg;

    logic        req_load;
    logic        req_store;
    logic        req_error;
    logic [3:0]  req_be;
    logic [31:0] req_wd;
    logic [31:0] align_result;

    // Decode of the incoming request, used only on the accepting edge.
    always_comb begin
        req_load  = op_is_load(op);
        req_store = op_is_store(op);
        req_error = !(req_load || req_store) || op_misaligned(op, addr[1:0]);
        req_be    = lane_enable(op, addr[1:0]);
        case (op)
            OP_SB:   req_wd = {4{rt_data[7:0]}};
            OP_SH:   req_wd = {2{rt_data[15:0]}};
            OP_SW:   req_wd = rt_data;
            default: req_wd = 32'h0;
        endcase
    end

    load_align u_load_align (
        .op       (op_reg),
        .lane     (lane_reg),
        .mem_word (dp_data),
        .rt_word  (rt_reg),
        .result   (align_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= 4'h0;
            lane_reg   <= 2'b00;
            rt_reg     <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            addr_error <= 1'b0;
            load_data  <= 32'h0;
            dp_address <= 32'h0;
            writedata  <= 32'h0;
            byteenable <= 4'h0;
            read_dp    <= 1'b0;
            write_dp   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg   <= op;
                        lane_reg <= addr[1:0];
                        rt_reg   <= rt_data;
                        busy     <= 1'b1;
                        if (req_error) begin
                            // Rejected request: straight to completion,
                            // the data port is never driven.
                            state_reg  <= ST_DONE;
                            done       <= 1'b1;
                            addr_error <= 1'b1;
                        end else begin
                            state_reg  <= ST_ACCESS;
                            dp_address <= {addr[31:2], 2'b00};
                            byteenable <= req_be;
                            writedata  <= req_wd;
                            read_dp    <= req_load;
                            write_dp   <= req_store;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!stall) begin
                        state_reg  <= ST_DONE;
                        done       <= 1'b1;
                        byteenable <= 4'h0;
                        writedata  <= 32'h0;
                        read_dp    <= 1'b0;
                        write_dp   <= 1'b0;
                        // read_dp doubles as the "this is a load" flag
                        if (read_dp) begin
                            load_data <= align_result;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg  <= ST_IDLE;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    addr_error <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  op = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] rt_data = 32'h0;
    logic        busy, done, addr_error, read_dp, write_dp;
    logic [31:0] load_data, dp_address, writedata, dp_data;
    logic [3:0]  byteenable;

    logic [31:0] mem [16];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_load = 32'h0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic        err;
        logic        is_load;
        logic        is_store;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] wd;
        int          lat;
        int          nstrobe;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    assign dp_data = read_dp ? mem[dp_address[5:2]] : 32'h5A5A_A5A5;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .rt_data    (rt_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .addr_error (addr_error),
        .dp_address (dp_address),
        .writedata  (writedata),
        .byteenable (byteenable),
        .read_dp    (read_dp),
        .write_dp   (write_dp),
        .dp_data    (dp_data),
        .stall      (stall)
    );

    // ---------------- reference model ----------------
    function automatic logic f_is_load(input logic [3:0] o);
        return (o <= 4'd6);
    endfunction

    function automatic logic f_is_store(input logic [3:0] o);
        return (o == 4'd8) || (o == 4'd9) || (o == 4'd10);
    endfunction

    function automatic logic f_err(input logic [3:0] o, input logic [31:0] a);
        if (!f_is_load(o) && !f_is_store(o)) return 1'b1;
        if ((o == 4'd2 || o == 4'd3 || o == 4'd9) && a[0]) return 1'b1;
        if ((o == 4'd4 || o == 4'd10) && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [3:0] f_be(input logic [3:0] o, input logic [31:0] a);
        logic [3:0] be;
        int k;
        k = int'(a[1:0]);
        be = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            case (o)
                4'd0, 4'd1, 4'd8: be[i] = (i == k);
                4'd2, 4'd3, 4'd9: be[i] = ((i / 2) == (k / 2));
                4'd4, 4'd10:      be[i] = 1'b1;
                4'd5:             be[i] = (i <= k);
                4'd6:             be[i] = (i >= k);
                default:          be[i] = 1'b0;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] f_wd(input logic [3:0] o, input logic [31:0] r);
        case (o)
            4'd8:    return {r[7:0], r[7:0], r[7:0], r[7:0]};
            4'd9:    return {r[15:0], r[15:0]};
            4'd10:   return r;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [3:0] o, input logic [31:0] a,
                                           input logic [31:0] m, input logic [31:0] r);
        logic [7:0]  mb [4];
        logic [7:0]  rb [4];
        logic [7:0]  ob [4];
        logic [15:0] h;
        int k;
        k = int'(a[1:0]);
        for (int i = 0; i < 4; i++) begin
            mb[i] = m[8*i +: 8];
            rb[i] = r[8*i +: 8];
        end
        h = (k >= 2) ? {mb[3], mb[2]} : {mb[1], mb[0]};
        case (o)
            4'd0: return mb[k][7] ? {24'hFFFFFF, mb[k]} : {24'h0, mb[k]};
            4'd1: return {24'h0, mb[k]};
            4'd2: return h[15] ? {16'hFFFF, h} : {16'h0, h};
            4'd3: return {16'h0, h};
            4'd4: return m;
            4'd5: begin
                for (int i = 0; i < 4; i++)
                    ob[i] = (i >= 3 - k) ? mb[i - (3 - k)] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            4'd6: begin
                for (int i = 0; i < 4; i++)
                    ob[i] = (i <= 3 - k) ? mb[i + k] : rb[i];
                return {ob[3], ob[2], ob[1], ob[0]};
            end
            default: return 32'h0;
        endcase
    endfunction

    // ---------------- generic access driver ----------------
    // Must be called at a negedge with the DUT idle.
    task automatic run_access(input logic [3:0] o, input logic [31:0] a, input logic [31:0] r,
                              input int nstall, input bit hold);
        exp_t e, got;
        int cyc, strobes;
        bit seen_done;
        e.op       = o;
        e.addr     = a;
        e.err      = f_err(o, a);
        e.is_load  = !e.err && f_is_load(o);
        e.is_store = !e.err && f_is_store(o);
        e.data     = e.is_load ? f_load(o, a, mem[a[5:2]], r) : last_load;
        e.be       = f_be(o, a);
        e.wd       = f_wd(o, r);
        e.lat      = e.err ? 1 : 2 + nstall;
        e.nstrobe  = e.err ? 0 : nstall + 1;
        got        = e;
        start = 1'b1; op = o; addr = a; rt_data = r; stall = 1'b0;
        sb_q.push_back(e);
        cyc = 0; strobes = 0; seen_done = 0;
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            stall = (cyc <= nstall);
            if (hold && done !== 1'b1) begin
                start = 1'b1; op = ~o; addr = ~a; rt_data = ~r;
            end else begin
                start = 1'b0;
            end
            vectors++;
            if (read_dp === 1'b1 && write_dp === 1'b1) begin
                miscompares++;
                $display("FAIL strobe_excl op=%0d addr=%h: read_dp=%b write_dp=%b, want not both", o, a, read_dp, write_dp);
            end
            vectors++;
            if (addr_error === 1'b1 && done !== 1'b1) begin
                miscompares++;
                $display("FAIL err_without_done op=%0d addr=%h cyc=%0d: addr_error=1 done=%b", o, a, cyc, done);
            end
            if (read_dp === 1'b1 || write_dp === 1'b1) begin
                strobes++;
                vectors++;
                if ({read_dp, write_dp, byteenable, writedata, dp_address, busy} !==
                    {e.is_load, e.is_store, e.be, e.wd, {a[31:2], 2'b00}, 1'b1}) begin
                    miscompares++;
                    $display("FAIL port op=%0d addr=%h cyc=%0d: rd=%b wr=%b be=%b wd=%h da=%h busy=%b, want rd=%b wr=%b be=%b wd=%h da=%h busy=1",
                             o, a, cyc, read_dp, write_dp, byteenable, writedata, dp_address, busy,
                             e.is_load, e.is_store, e.be, e.wd, {a[31:2], 2'b00});
                end
            end
            if (done === 1'b1) begin
                seen_done = 1;
                got = sb_q.pop_front();
                vectors++;
                if (cyc != got.lat) begin
                    miscompares++;
                    $display("FAIL latency op=%0d addr=%h: done at n+%0d, want n+%0d", got.op, got.addr, cyc, got.lat);
                end
                vectors++;
                if ({addr_error, busy, load_data} !== {got.err, 1'b1, got.data}) begin
                    miscompares++;
                    $display("FAIL completion op=%0d addr=%h: addr_error=%b busy=%b load_data=%h, want addr_error=%b busy=1 load_data=%h",
                             got.op, got.addr, addr_error, busy, load_data, got.err, got.data);
                end
                vectors++;
                if (strobes != got.nstrobe) begin
                    miscompares++;
                    $display("FAIL strobe_cycles op=%0d addr=%h: %0d cycles, want %0d", got.op, got.addr, strobes, got.nstrobe);
                end
            end
        end
        start = 1'b0; stall = 1'b0;
        vectors++;
        if (!seen_done) begin
            miscompares++;
            $display("FAIL timeout op=%0d addr=%h: no done within 40 cycles, want done", o, a);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(negedge clk);
        vectors++;
        if ({done, busy, addr_error, read_dp, write_dp, byteenable} !== 9'b0) begin
            miscompares++;
            $display("FAIL after_done op=%0d addr=%h: done=%b busy=%b err=%b rd=%b wr=%b be=%b, want all 0",
                     o, a, done, busy, addr_error, read_dp, write_dp, byteenable);
        end
        $display("txn op=%0d addr=%h rt=%h stall=%0d -> err=%b load_data=%h", o, a, r, nstall, addr_error, load_data);
        if (got.is_load) last_load = got.data;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, done, addr_error, read_dp, write_dp, byteenable, writedata, dp_address, load_data} !== 105'b0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b err=%b rd=%b wr=%b be=%b wd=%h da=%h ld=%h, want all 0",
                     busy, done, addr_error, read_dp, write_dp, byteenable, writedata, dp_address, load_data);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
        end
        last_load = 32'h0;
    endtask

    task automatic test_lw;
        mem[4] = 32'hDEADBEEF;
        run_access(4'd4, 32'h10, 32'h0, 0, 0);
        vectors++;
        if (load_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL lw_value: load_data=%h, want DEADBEEF", load_data);
        end
    endtask

    task automatic test_lb_lbu;
        mem[4] = 32'h80112233;
        run_access(4'd0, 32'h13, 32'h0, 0, 0);
        vectors++;
        if (load_data !== 32'hFFFFFF80) begin
            miscompares++;
            $display("FAIL lb_value: load_data=%h, want FFFFFF80", load_data);
        end
        run_access(4'd1, 32'h13, 32'h0, 0, 0);
        vectors++;
        if (load_data !== 32'h00000080) begin
            miscompares++;
            $display("FAIL lbu_value: load_data=%h, want 00000080", load_data);
        end
        mem[5] = 32'h8001_7FFE;
        run_access(4'd2, 32'h16, 32'h0, 0, 0);
        run_access(4'd3, 32'h14, 32'h0, 0, 0);
    endtask

    task automatic test_stores;
        run_access(4'd9, 32'h22, 32'h00001234, 0, 0);
        run_access(4'd8, 32'h31, 32'hA5A5_C3C3, 0, 0);
        vectors++;
        if (load_data !== last_load) begin
            miscompares++;
            $display("FAIL store_keeps_load: load_data=%h, want %h", load_data, last_load);
        end
    endtask

    task automatic test_errors;
        run_access(4'd4, 32'h11, 32'h0, 0, 0);
        run_access(4'd7, 32'h10, 32'h0, 0, 0);
        run_access(4'd3, 32'h01, 32'h0, 0, 0);
        run_access(4'd10, 32'h02, 32'h0, 2, 0);
        run_access(4'd15, 32'h00, 32'h0, 0, 0);
    endtask

    task automatic test_lwl_lwr;
        mem[0] = 32'hAABBCCDD;
        run_access(4'd5, 32'h01, 32'h11223344, 0, 1);
        vectors++;
        if (load_data !== 32'hCCDD3344) begin
            miscompares++;
            $display("FAIL lwl_value: load_data=%h, want CCDD3344", load_data);
        end
        run_access(4'd6, 32'h01, 32'h11223344, 0, 1);
        vectors++;
        if (load_data !== 32'h11AABBCC) begin
            miscompares++;
            $display("FAIL lwr_value: load_data=%h, want 11AABBCC", load_data);
        end
        run_access(4'd5, 32'h03, 32'h11223344, 1, 0);
        run_access(4'd6, 32'h00, 32'h11223344, 0, 0);
    endtask

    task automatic test_stall_sw;
        run_access(4'd10, 32'h24, 32'hCAFEF00D, 3, 0);
    endtask

    task automatic test_reset_mid_stall;
        int done_seen;
        start = 1'b1; op = 4'd10; addr = 32'h28; rt_data = 32'h1357_9BDF; stall = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++;
        if ({write_dp, busy} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_stall_active: write_dp=%b busy=%b, want 1 1", write_dp, busy);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, addr_error, read_dp, write_dp, byteenable, writedata, dp_address, load_data} !== 105'b0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b done=%b err=%b rd=%b wr=%b be=%b wd=%h da=%h ld=%h, want all 0",
                     busy, done, addr_error, read_dp, write_dp, byteenable, writedata, dp_address, load_data);
        end
        @(negedge clk);
        rst = 1'b0; stall = 1'b0;
        last_load = 32'h0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        vectors++;
        if (done_seen != 0) begin
            miscompares++;
            $display("FAIL reset_no_done: %0d cycles with done/busy after reset, want 0", done_seen);
        end
        $display("txn reset mid-stall SW addr=00000028 -> aborted");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        for (int i = 0; i < 24; i++) begin
            run_access(4'($urandom_range(0, 15)), $urandom, $urandom,
                       $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        test_reset();
        test_lw();
        test_lb_lbu();
        test_stores();
        test_errors();
        test_lwl_lwr();
        test_stall_sw();
        test_reset_mid_stall();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 start  in  1  request strobe, sampled in IDLE only.
REQ-004 op  in  4  access type per shared op encoding.
REQ-005 addr  in  32  byte address of access.
REQ-006 rt_data  in  32  store source; merge source for LWL/LWR.
REQ-007 busy  out  1  high from accepted start until done cycle inclusive.
REQ-008 done  out  1  one-cycle completion pulse.
REQ-009 load_data  out  32  extended/merged load result, held until next done.
REQ-010 addr_error  out  1  valid with done: misaligned or invalid op, no memory access made.
REQ-011 dp_address  out  32  word address to memory: {addr[31:2],2'b00}.
REQ-012 writedata, byteenable, read_dp, write_dp  out  32/4/1/1  data-port request; lane k = byte at dp_address+k (little-endian lanes).
REQ-013 dp_data  in  32  memory read data; valid combinationally while read_dp high.
REQ-014 stall  in  1  memory not ready; current request held while high.

Function
REQ-015 FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on start with legal op/alignment; IDLE->DONE on start with error; ACCESS->DONE when stall low at clock edge; DONE->IDLE unconditionally.
REQ-016 start captures op, addr, rt_data into internal registers; start while busy is ignored.
REQ-017 Legal ops: LB 0, LBU 1, LH 2, LHU 3, LW 4, LWL 5, LWR 6, SB 8, SH 9, SW 10; any other code sets addr_error.
REQ-018 Misalignment: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 set addr_error; LB/LBU/SB/LWL/LWR never misaligned.
REQ-019 read_dp (loads) or write_dp (stores) high only in ACCESS; never both; both low in IDLE/DONE.
REQ-020 byteenable: byte ops 1<<addr[1:0]; half ops 0011 (addr[1]=0) or 1100; word 1111; LWL lanes 0..k; LWR lanes k..3 (k=addr[1:0]); 0000 outside ACCESS.
REQ-021 writedata: SB {4{rt[7:0]}}; SH {2{rt[15:0]}}; SW rt; 0 for loads.
REQ-022 Load result captured from dp_data at the ACCESS->DONE edge: LB/LH sign-extend selected lane(s); LBU/LHU zero-extend; LW whole word.
REQ-023 LWL: result = (dp_data << 8*(3-k)) | (rt_data & low 8*(3-k) bits mask); LWR: result = (dp_data >> 8*k) | (rt_data & high 8*k bits mask).
REQ-024 Stores leave load_data unchanged; error completions leave load_data unchanged.
REQ-025 Latency, no stall: start sampled edge n, ACCESS cycle n+1, done high cycle n+2; each stalled cycle adds one.
REQ-026 While stall high in ACCESS, dp_address, writedata, byteenable, strobes held bit-stable.
REQ-027 Error path: done and addr_error high cycle n+1, no strobe ever asserted.
REQ-028 addr_error low whenever done low.

Reset
REQ-029 Reset asserted at any time (including mid-ACCESS) forces IDLE immediately; busy, done, addr_error, read_dp, write_dp, byteenable, writedata, dp_address, load_data all 0.
REQ-030 An access interrupted by reset does not produce done after reset release.

Structure
REQ-031 Op encoding constants and FSM state typedef live in shared package mips_mem_pkg.
REQ-032 Lane-select/extend/merge logic in one combinational sub-module load_align; store lane replication inline.

Verification
REQ-033 LW addr 0x10, memory word 0xDEADBEEF, no stall -> done at n+2, load_data 0xDEADBEEF, byteenable 1111.
REQ-034 LB addr 0x13, lane 3 = 0x80 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x22, rt 0x00001234 -> byteenable 1100, writedata 0x12341234, write_dp one cycle.
REQ-036 LW addr 0x11 -> done+addr_error at n+1, read_dp never high; op 7 -> same.
REQ-037 LWL addr 0x01, mem 0xAABBCCDD, rt 0x11223344 -> 0xCCDD3344; LWR addr 0x01 -> 0x11AABBCC.
REQ-038 SW with stall high 3 cycles -> outputs stable, done at n+5; rst asserted mid-stall -> IDLE, no done.
